dma_desc_queue: RTL

//  Descriptor queue and launcher directly upstream of dma_func_wrapper.

---
 rtl/dma_pkg.sv | 34 +++
 rtl/dma_desc_fifo.sv | 57 +++++
 rtl/dma_desc_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dma_pkg : shared DMA descriptor/status types and queue FSM states  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dma_pkg;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic active;
    logic done;
    logic error;
  } s_dma_status_t;

  typedef struct packed {
    logic [31:0] err_addr;
    logic [1:0]  err_resp;
    logic        err_is_read;
  } s_dma_error_t;

  typedef enum logic [1:0] {
    DQ_IDLE   = 2'd0,
    DQ_LAUNCH = 2'd1,
    DQ_RUN    = 2'd2,
    DQ_HALT   = 2'd3
  } e_dq_state_t;

endpackage
`default_nettype wire

// File: rtl/dma_desc_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dma_desc_fifo : sync descriptor FIFO with flush and fill level     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dma_desc_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  s_dma_desc_t               push_desc,
  input  logic                      pop,
  input  logic                      flush,
  output s_dma_desc_t               head,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0] r_wr_ptr;
  logic [c_aw:0] r_rd_ptr;
  s_dma_desc_t   r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  // Extra wrap bit on each pointer separates full from empty.
  assign level = r_wr_ptr - r_rd_ptr;
  assign full  = (level == (c_aw+1)'(DEPTH));
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign head  = r_mem[r_rd_ptr[c_aw-1:0]];

  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_desc;
  end

endmodule
`default_nettype wire

// File: rtl/dma_desc_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dma_desc_queue : queues descriptors and launches them one by one   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dma_desc_queue
  import dma_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int CNT_W         = 16,
  parameter bit STOP_ON_ERROR = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  s_dma_desc_t                push_desc_i,
  input  logic                       flush_i,
  input  logic                       err_clr_i,
  output logic                       dma_go_o,
  output s_dma_desc_t                dma_desc_o,
  input  s_dma_status_t              dma_stats_i,
  input  s_dma_error_t               dma_error_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           done_cnt_o,
  output logic                       err_o,
  output s_dma_error_t               err_src_o,
  output logic                       drained_o
);

  localparam int c_lvl_w = $clog2(DEPTH+1);

  e_dq_state_t          r_state;
  e_dq_state_t          w_state_nxt;
  s_dma_desc_t          w_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_pop;
  logic                 w_done_inc;
  logic                 w_err_set;
  logic                 w_push_acc;
  logic                 r_run_err;
  logic [c_lvl_w-1:0]   w_level_after;

  dma_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_valid_i),
    .push_desc (push_desc_i),
    .pop       (w_pop),
    .flush     (flush_i),
    .head      (w_head),
    .level     (level_o),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign push_ready_o  = !w_fifo_full;
  assign w_push_acc    = push_valid_i && !w_fifo_full && !flush_i;
  assign w_level_after = level_o - c_lvl_w'(w_pop);
  assign dma_go_o      = (r_state == DQ_LAUNCH);
  assign busy_o        = (r_state != DQ_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done_inc  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      DQ_IDLE: begin
        if (!w_fifo_empty && !flush_i && !(err_o && STOP_ON_ERROR)) begin
          w_pop = 1'b1;
          // Zero-length descriptors retire immediately without touching the DMA.
          if (w_head.num_bytes == 32'd0) w_done_inc  = 1'b1;
          else                           w_state_nxt = DQ_LAUNCH;
        end
      end
      DQ_LAUNCH: begin
        if (dma_stats_i.active) w_state_nxt = DQ_RUN;
      end
      DQ_RUN: begin
        w_err_set = dma_stats_i.error;
        if (dma_stats_i.done || !dma_stats_i.active) begin
          w_done_inc  = 1'b1;
          w_state_nxt = ((r_run_err || dma_stats_i.error) && STOP_ON_ERROR) ? DQ_HALT : DQ_IDLE;
        end
      end
      DQ_HALT: begin
        if (err_clr_i) w_state_nxt = DQ_IDLE;
      end
      default: w_state_nxt = DQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DQ_IDLE;
      dma_desc_o <= '0;
      done_cnt_o <= '0;
      err_o      <= 1'b0;
      err_src_o  <= '0;
      r_run_err  <= 1'b0;
      drained_o  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      drained_o <= w_done_inc && (w_level_after == '0) && !w_push_acc;
      if (w_pop)      dma_desc_o <= w_head;
      if (w_done_inc) done_cnt_o <= done_cnt_o + CNT_W'(1);
      if (w_pop)          r_run_err <= 1'b0;
      else if (w_err_set) r_run_err <= 1'b1;
      // A fresh error outranks a simultaneous clear; only the first error is captured.
      if (w_err_set) begin
        err_o <= 1'b1;
        if (!err_o) err_src_o <= dma_error_i;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
